rpe_prefix_tx: RTL and testbench

- Transmit-side counterpart of the team's prefix-expression receiver.
- Accepts one packed postfix (RPE) expression of N_TOK 5-bit tokens, converts it to prefix order, and streams it out one token per cycle.
- The output uses the receiver's input protocol (valid / opt-on-first-token / 5-bit data), so the two blocks connect back to back.
- Token format: bit4=1 is an operator, [1:0] 00 +, 01 -, 10 *, 11 /. bit4=0 is an operand, value in [3:0].

---
 rtl/rpe_prefix_tx_pkg.sv | 30 +++
 rtl/rpe_prefix_tx_idx_stack.sv | 77 +++++++
 rtl/rpe_prefix_tx.sv | 201 ++++++++++++++++++++
 tb/tb_rpe_prefix_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rpe_prefix_tx_pkg.sv
// Shared token definitions for the RPE prefix transmitter and receiver.
package rpe_prefix_tx_pkg;

  localparam int TOK_W = 5;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef struct packed {
    logic [1:0] rsv;
    logic [1:0] opcode;
  } op_body_t;

  typedef union packed {
    logic [3:0] value;
    op_body_t   op;
  } tok_body_t;

  typedef struct packed {
    logic      is_op;
    tok_body_t body;
  } rpe_tok_t;

  function automatic logic is_operator(input rpe_tok_t tok);
    return tok.is_op;
  endfunction

endpackage

// File: rtl/rpe_prefix_tx_idx_stack.sv
// Index stack with one combined update per cycle: up to two pops, then up to two pushes.
module rpe_idx_stack
  import rpe_prefix_tx_pkg::*;
#(
  parameter int STK_D = 10,
  parameter int IW    = 5,
  parameter int SP_W  = $clog2(STK_D + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            seed,
  input  logic [IW-1:0]   seed_idx,
  input  logic [1:0]      pop_cnt,
  input  logic [1:0]      push_cnt,
  input  logic [IW-1:0]   push0,
  input  logic [IW-1:0]   push1,
  output logic [IW-1:0]   top,
  output logic [IW-1:0]   second,
  output logic [SP_W-1:0] depth,
  output logic            underflow,
  output logic            overflow
);

  localparam int MEM_D = 1 << SP_W;

  logic [IW-1:0]   mem_r [MEM_D];
  logic [SP_W-1:0] sp_r;
  logic [SP_W-1:0] base_s;
  logic [SP_W-1:0] slot1_s;
  logic [SP_W-1:0] sp_nxt_s;
  logic            wr0_s;
  logic            wr1_s;

  // Pops land first; push1 ends up on top. The pointer saturates at 0 and STK_D.
  always_comb begin
    underflow = 1'b0;
    overflow  = 1'b0;
    if (SP_W'(pop_cnt) > sp_r) begin
      underflow = 1'b1;
      base_s    = '0;
    end else begin
      base_s = sp_r - SP_W'(pop_cnt);
    end
    slot1_s = base_s + SP_W'(1);
    wr0_s   = (push_cnt != 2'd0) && (int'(base_s) < STK_D);
    wr1_s   = (push_cnt == 2'd2) && (int'(base_s) + 1 < STK_D);
    if (int'(base_s) + int'(push_cnt) > STK_D) begin
      overflow = 1'b1;
      sp_nxt_s = SP_W'(STK_D);
    end else begin
      sp_nxt_s = base_s + SP_W'(push_cnt);
    end
  end

  assign top    = (sp_r != '0) ? mem_r[sp_r - SP_W'(1)] : '0;
  assign second = (sp_r > SP_W'(1)) ? mem_r[sp_r - SP_W'(2)] : '0;
  assign depth  = sp_r;

  // Pointer and storage update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_r <= '0;
      for (int k = 0; k < MEM_D; k++) mem_r[k] <= '0;
    end else if (clr) begin
      sp_r <= '0;
    end else if (seed) begin
      sp_r     <= SP_W'(1);
      mem_r[0] <= seed_idx;
    end else begin
      sp_r <= sp_nxt_s;
      if (wr0_s) mem_r[base_s]  <= push0;
      if (wr1_s) mem_r[slot1_s] <= push1;
    end
  end

endmodule

// File: rtl/rpe_prefix_tx.sv
// Postfix-to-prefix token streamer feeding the prefix receiver's input protocol.
// Optional malformed-expression checking is enabled by defining RPE_TX_CHECK_EN.
module rpe_prefix_tx
  import rpe_prefix_tx_pkg::*;
#(
  parameter int N_TOK = 19,
  parameter int STK_D = (N_TOK + 1) / 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_opt,
  input  logic [TOK_W*N_TOK-1:0] in_expr,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic                   out_opt,
  output logic [TOK_W-1:0]       out_data,
  output logic                   err
);

  localparam int IW    = $clog2(N_TOK);
  localparam int SP_W  = $clog2(STK_D + 1);
  localparam int ARR_D = 1 << IW;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_TOK - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  logic [1:0]      state_r;
  logic [IW-1:0]   cnt_r;
  rpe_tok_t        tok_r   [ARR_D];
  logic [IW-1:0]   start_r [ARR_D];
  logic            opt_r;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            out_opt_r;
  rpe_tok_t        out_data_r;

  logic            stk_clr_s, stk_seed_s;
  logic [1:0]      stk_pop_s, stk_push_s;
  logic [IW-1:0]   push0_s, push1_s, stk_top_s, stk_second_s;
  logic [SP_W-1:0] stk_depth_s;
  logic            stk_uf_s, stk_of_s;
  rpe_tok_t        cur_tok_s, emit_tok_s;
  logic [IW-1:0]   right_s, left_s;
  logic            scan_fail_s;
  logic            unused_stack_s;

  rpe_idx_stack #(.STK_D(STK_D), .IW(IW), .SP_W(SP_W)) u_stack (
    .clk(clk), .rst_n(rst_n), .clr(stk_clr_s), .seed(stk_seed_s), .seed_idx(LAST_IDX),
    .pop_cnt(stk_pop_s), .push_cnt(stk_push_s), .push0(push0_s), .push1(push1_s),
    .top(stk_top_s), .second(stk_second_s), .depth(stk_depth_s),
    .underflow(stk_uf_s), .overflow(stk_of_s)
  );

  assign unused_stack_s = ^{stk_uf_s, stk_of_s, stk_depth_s};

  assign cur_tok_s  = tok_r[cnt_r];
  assign emit_tok_s = tok_r[stk_top_s];
  assign right_s    = stk_top_s - IW'(1);
  assign left_s     = start_r[right_s] - IW'(1);

  // Stack control: the last SCAN cycle reseeds with the root instead of pushing.
  always_comb begin
    stk_clr_s  = 1'b0;
    stk_seed_s = 1'b0;
    stk_pop_s  = 2'd0;
    stk_push_s = 2'd0;
    push0_s    = '0;
    push1_s    = '0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) stk_clr_s = 1'b1;
        else          stk_clr_s = 1'b0;
      end
      ST_SCAN: begin
        push0_s = cnt_r;
        if (cnt_r == LAST_IDX) begin
          stk_seed_s = 1'b1;
        end else if (is_operator(cur_tok_s)) begin
          stk_pop_s  = 2'd2;
          stk_push_s = 2'd1;
        end else begin
          stk_push_s = 2'd1;
        end
      end
      ST_EMIT: begin
        stk_pop_s = 2'd1;
        push0_s   = right_s;
        push1_s   = left_s;
        if (is_operator(emit_tok_s)) stk_push_s = 2'd2;
        else                         stk_push_s = 2'd0;
      end
      default: begin
        stk_clr_s = 1'b1;
      end
    endcase
  end

`ifdef RPE_TX_CHECK_EN
  logic            scan_bad_r, err_r, scan_uf_s;
  logic [SP_W:0]   final_depth_s;

  // Malformed detection: operator with <2 entries, or final depth other than one.
  always_comb begin
    scan_uf_s = is_operator(cur_tok_s) && (stk_depth_s < SP_W'(2));
    if (is_operator(cur_tok_s)) final_depth_s = {1'b0, stk_depth_s} - (SP_W+1)'(1);
    else                        final_depth_s = {1'b0, stk_depth_s} + (SP_W+1)'(1);
    scan_fail_s = (state_r == ST_SCAN) && (cnt_r == LAST_IDX) &&
                  (scan_bad_r || scan_uf_s || (final_depth_s != (SP_W+1)'(1)));
  end

  // Error accumulation and the one-cycle err pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_bad_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      err_r <= scan_fail_s;
      if (state_r == ST_SCAN) scan_bad_r <= scan_bad_r | scan_uf_s;
      else                    scan_bad_r <= 1'b0;
    end
  end

  assign err = err_r;
`else
  assign scan_fail_s = 1'b0;
  assign err         = 1'b0;
`endif

  // Main sequencer: accept, index scan, prefix emission.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      opt_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_opt_r   <= 1'b0;
      out_data_r  <= '0;
      for (int k = 0; k < ARR_D; k++) begin
        tok_r[k]   <= '0;
        start_r[k] <= '0;
      end
    end else begin
      out_valid_r <= 1'b0;
      out_opt_r   <= 1'b0;
      out_data_r  <= '0;
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < N_TOK; k++)
              tok_r[k] <= in_expr[TOK_W*(N_TOK-1-k) +: TOK_W];
            opt_r      <= in_opt;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          start_r[cnt_r] <= is_operator(cur_tok_s) ? start_r[stk_second_s] : cnt_r;
          if (cnt_r == LAST_IDX) begin
            cnt_r <= '0;
            if (scan_fail_s) begin
              in_ready_r <= 1'b1;
              state_r    <= ST_IDLE;
            end else begin
              state_r <= ST_EMIT;
            end
          end else begin
            cnt_r <= cnt_r + IW'(1);
          end
        end
        ST_EMIT: begin
          out_valid_r <= 1'b1;
          out_data_r  <= emit_tok_s;
          out_opt_r   <= (cnt_r == '0) ? opt_r : 1'b0;
          if (cnt_r == LAST_IDX) begin
            cnt_r      <= '0;
            in_ready_r <= 1'b1;
            state_r    <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + IW'(1);
          end
        end
        default: begin
          cnt_r      <= '0;
          in_ready_r <= 1'b1;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_opt   = out_opt_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_rpe_prefix_tx.sv
// Scoreboard bench for rpe_prefix_tx: N_TOK=19 and N_TOK=7 instances.
module tb_rpe_prefix_tx;

  typedef logic [4:0] tok_t;
  typedef struct {
    logic [4:0] data;
    logic       opt;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc_r = 0;
  int   tests = 0;
  int   fails = 0;

  logic        in_valid19, in_opt19, in_ready19, out_valid19, out_opt19, err19;
  logic [94:0] in_expr19;
  logic [4:0]  out_data19;
  logic        in_valid7, in_opt7, in_ready7, out_valid7, out_opt7, err7;
  logic [34:0] in_expr7;
  logic [4:0]  out_data7;

  exp_t q19[$];
  exp_t q7[$];

  tok_t ld_post [19] = '{5'h01, 5'h02, 5'h10, 5'h03, 5'h10, 5'h04, 5'h10, 5'h05, 5'h10, 5'h06,
                         5'h10, 5'h07, 5'h10, 5'h08, 5'h10, 5'h09, 5'h10, 5'h0A, 5'h10};
  tok_t ld_pre  [19] = '{5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h01,
                         5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A};
  tok_t rd_post [19] = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A,
                         5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11};
  tok_t rd_pre  [19] = '{5'h11, 5'h01, 5'h11, 5'h02, 5'h11, 5'h03, 5'h11, 5'h04, 5'h11, 5'h05,
                         5'h11, 5'h06, 5'h11, 5'h07, 5'h11, 5'h08, 5'h11, 5'h09, 5'h0A};
  tok_t mx_post [19] = '{5'h01, 5'h02, 5'h12, 5'h03, 5'h04, 5'h13, 5'h10, 5'h05, 5'h06, 5'h11,
                         5'h07, 5'h08, 5'h10, 5'h12, 5'h13, 5'h09, 5'h11, 5'h0F, 5'h12};
  tok_t mx_pre  [19] = '{5'h12, 5'h11, 5'h13, 5'h10, 5'h12, 5'h01, 5'h02, 5'h13, 5'h03, 5'h04,
                         5'h12, 5'h11, 5'h05, 5'h06, 5'h10, 5'h07, 5'h08, 5'h09, 5'h0F};
  tok_t s7_post [7]  = '{5'h01, 5'h02, 5'h12, 5'h03, 5'h04, 5'h13, 5'h10};
  tok_t s7_pre  [7]  = '{5'h10, 5'h12, 5'h01, 5'h02, 5'h13, 5'h03, 5'h04};

  rpe_prefix_tx #(.N_TOK(19)) dut19 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid19), .in_opt(in_opt19), .in_expr(in_expr19),
    .in_ready(in_ready19), .out_valid(out_valid19), .out_opt(out_opt19),
    .out_data(out_data19), .err(err19)
  );

  rpe_prefix_tx #(.N_TOK(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid7), .in_opt(in_opt7), .in_expr(in_expr7),
    .in_ready(in_ready7), .out_valid(out_valid7), .out_opt(out_opt7),
    .out_data(out_data7), .err(err7)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_r <= cyc_r + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor for the 19-token instance.
  always @(negedge clk) begin : mon19
    exp_t e;
    if (rst_n) begin
      tests++;
      if (out_valid19) begin
        if (q19.size() == 0) begin
          fails++;
          $display("FAIL out19_extra: got data=%h, required no output", out_data19);
        end else begin
          e = q19.pop_front();
          if (out_data19 !== e.data || out_opt19 !== e.opt || (e.cyc >= 0 && cyc_r != e.cyc)) begin
            fails++;
            $display("FAIL out19: got data=%h opt=%b cyc=%0d, required data=%h opt=%b cyc=%0d",
                     out_data19, out_opt19, cyc_r, e.data, e.opt, e.cyc);
          end
        end
      end else if (out_data19 !== 5'h00 || out_opt19 !== 1'b0) begin
        fails++;
        $display("FAIL out19_idle: got data=%h opt=%b, required 00/0", out_data19, out_opt19);
      end
    end
  end

  // Monitor for the 7-token instance.
  always @(negedge clk) begin : mon7
    exp_t e;
    if (rst_n) begin
      tests++;
      if (out_valid7) begin
        if (q7.size() == 0) begin
          fails++;
          $display("FAIL out7_extra: got data=%h, required no output", out_data7);
        end else begin
          e = q7.pop_front();
          if (out_data7 !== e.data || out_opt7 !== e.opt || (e.cyc >= 0 && cyc_r != e.cyc)) begin
            fails++;
            $display("FAIL out7: got data=%h opt=%b cyc=%0d, required data=%h opt=%b cyc=%0d",
                     out_data7, out_opt7, cyc_r, e.data, e.opt, e.cyc);
          end
        end
      end else if (out_data7 !== 5'h00 || out_opt7 !== 1'b0) begin
        fails++;
        $display("FAIL out7_idle: got data=%h opt=%b, required 00/0", out_data7, out_opt7);
      end
    end
  end

  // Called at a negedge; waits for in_ready, offers one expression, queues its prefix.
  task automatic send19(input tok_t post[19], input tok_t pre[19], input logic opt, output int acc);
    int w = 0;
    while (!in_ready19 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("ready19_wait", int'(in_ready19), 1);
    for (int k = 0; k < 19; k++) in_expr19[5*(18-k) +: 5] = post[k];
    in_opt19   = opt;
    in_valid19 = 1'b1;
    for (int k = 0; k < 19; k++)
      q19.push_back('{data: pre[k], opt: (k == 0) ? opt : 1'b0, cyc: (k == 0) ? cyc_r + 21 : -1});
    acc = cyc_r + 1;
    @(posedge clk);
    #1 in_valid19 = 1'b0;
  endtask

  initial begin
    int acc;
    int w;
    int errs;
    rst_n = 1'b0;
    in_valid19 = 1'b0; in_opt19 = 1'b0; in_expr19 = '0;
    in_valid7  = 1'b0; in_opt7  = 1'b0; in_expr7  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(in_ready19), 1);
    check("rst_valid", int'(out_valid19), 0);
    check("rst_data", int'(out_data19), 0);
    check("rst_opt", int'(out_opt19), 0);
    check("rst_err", int'(err19), 0);
    check("rst_ready7", int'(in_ready7), 1);
    @(negedge clk) rst_n = 1'b1;

    // Left-deep, then in_valid during EMIT must be ignored.
    @(negedge clk);
    send19(ld_post, ld_pre, 1'b1, acc);
    w = 0;
    while (!out_valid19 && w < 100) begin @(negedge clk); w++; end
    check("emit19_seen", int'(out_valid19), 1);
    for (int k = 0; k < 3; k++) begin
      in_expr19 = {19{5'h01}};
      in_valid19 = 1'b1;
      check("busy_ready", int'(in_ready19), 0);
      @(negedge clk);
    end
    in_valid19 = 1'b0;
    w = 0;
    while (!in_ready19 && w < 100) begin @(negedge clk); w++; end
    check("ready_cycle", cyc_r - acc, 38);

    // Back-to-back: mixed expression offered as soon as in_ready returns.
    send19(mx_post, mx_pre, 1'b0, acc);
    @(negedge clk);
    send19(rd_post, rd_pre, 1'b1, acc);

    // Reset during EMIT.
    @(negedge clk);
    send19(mx_post, mx_pre, 1'b1, acc);
    while (cyc_r != acc + 24) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    q19.delete();
    #1;
    check("rst_mid_valid", int'(out_valid19), 0);
    check("rst_mid_data", int'(out_data19), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", int'(in_ready19), 1);
    send19(rd_post, rd_pre, 1'b0, acc);

    // N_TOK=7 instance.
    @(negedge clk);
    for (int k = 0; k < 7; k++) in_expr7[5*(6-k) +: 5] = s7_post[k];
    in_opt7 = 1'b1;
    in_valid7 = 1'b1;
    for (int k = 0; k < 7; k++)
      q7.push_back('{data: s7_pre[k], opt: (k == 0), cyc: (k == 0) ? cyc_r + 9 : -1});
    @(negedge clk);
    in_valid7 = 1'b0;

    w = 0;
    while ((q19.size() != 0 || q7.size() != 0) && w < 200) begin @(negedge clk); w++; end
    repeat (5) @(negedge clk);
    check("q19_drained", q19.size(), 0);
    check("q7_drained", q7.size(), 0);
    check("ready7_end", int'(in_ready7), 1);

`ifdef RPE_TX_CHECK_EN
    // Malformed expression: starts with an operator.
    for (int k = 0; k < 19; k++) in_expr19[5*(18-k) +: 5] = ld_post[k];
    in_expr19[94:90] = 5'h10;
    in_valid19 = 1'b1;
    @(negedge clk);
    in_valid19 = 1'b0;
    errs = 0;
    for (int k = 0; k < 45; k++) begin
      if (err19) errs++;
      @(negedge clk);
    end
    check("err_pulses", errs, 1);
    check("err_ready", int'(in_ready19), 1);
`else
    errs = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
